// File: rtl/quad_pkg.sv
// Shared types and constants for the quadrature encoder emulator.
package quad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // Forward phase order as {A,B}: 00 -> 10 -> 11 -> 01, entry i in bits [2i+1:2i]
  localparam logic [7:0] GRAY_TBL = {2'b01, 2'b11, 2'b10, 2'b00};

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  localparam int MIN_PERIOD_DEF = 2;

  function automatic logic [1:0] gray_of(input logic [1:0] idx);
    return GRAY_TBL[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/quad_step_timer.sv
// Loadable period down-counter; o_expire marks the last clock of a period.
module quad_step_timer #(
  parameter int PER_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [PER_W-1:0] i_load_val,
  output logic             o_expire
);

  localparam logic [PER_W-1:0] CNT_ONE = PER_W'(1);

  logic [PER_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

  assign o_expire = i_en && (r_cnt <= CNT_ONE);

endmodule

// File: rtl/quad_generator.sv
// Quadrature A/B encoder emulator with position count.
// Optional index pulse on quad_z when built with QUAD_INDEX_EN.
module quad_generator
  import quad_pkg::*;
#(
  parameter int STEP_W     = 16,
  parameter int PER_W      = 16,
  parameter int MIN_PERIOD = MIN_PERIOD_DEF,
  parameter int CPR        = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic [PER_W-1:0]  cmd_period,
  input  logic              abort,
  output logic              quad_a,
  output logic              quad_b,
  output logic              quad_z,
  output logic              busy,
  output logic              done,
  output logic [7:0]        position
);

  localparam logic [PER_W-1:0] MIN_P = PER_W'(MIN_PERIOD);
  localparam logic [PER_W-1:0] ONE_P = PER_W'(1);
  localparam int IDX_W = (CPR > 1) ? $clog2(CPR) : 1;

  state_t            r_state, w_state_nxt;
  logic [STEP_W:0]   r_remaining;
  logic              r_dir;
  logic [PER_W-1:0]  r_period;
  logic [1:0]        r_phase;
  logic [1:0]        r_ab;
  logic [7:0]        r_pos;

  logic              w_hs;
  logic [STEP_W:0]   w_steps_ext;
  logic [STEP_W:0]   w_abs;
  logic [PER_W-1:0]  w_per_clamp;
  logic              w_adv;
  logic [1:0]        w_phase_nxt;

  assign w_hs        = cmd_valid && (r_state == ST_IDLE);
  assign w_steps_ext = {cmd_steps[STEP_W-1], cmd_steps};
  // One extra bit keeps the magnitude of the most negative command exact
  assign w_abs       = cmd_steps[STEP_W-1] ? (~w_steps_ext + 1'b1) : w_steps_ext;
  assign w_per_clamp = (cmd_period < MIN_P) ? MIN_P : cmd_period;
  assign w_phase_nxt = (r_dir == DIR_FWD) ? (r_phase + 2'd1) : (r_phase - 2'd1);

  // The handshake clock already counts as the first clock of edge 1's period
  quad_step_timer #(.PER_W(PER_W)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_en      ((r_state == ST_RUN) && (r_remaining != '0)),
    .i_load    (w_hs || w_adv),
    .i_load_val(w_hs ? (w_per_clamp - ONE_P) : r_period),
    .o_expire  (w_adv)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_hs) w_state_nxt = (w_abs == '0) ? ST_FINISH : ST_RUN;
      end
      ST_RUN: begin
        if (abort)                    w_state_nxt = ST_IDLE;
        else if (r_remaining == '0)   w_state_nxt = ST_FINISH;
      end
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_dir       <= DIR_FWD;
      r_period    <= '0;
      r_phase     <= 2'd0;
      r_ab        <= 2'b00;
      r_pos       <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hs) begin
        r_remaining <= w_abs;
        r_dir       <= cmd_steps[STEP_W-1] ? DIR_REV : DIR_FWD;
        r_period    <= w_per_clamp;
      end else if (w_adv) begin
        r_remaining <= r_remaining - 1'b1;
        r_phase     <= w_phase_nxt;
        r_ab        <= gray_of(w_phase_nxt);
        r_pos       <= (r_dir == DIR_FWD) ? (r_pos + 8'd1) : (r_pos - 8'd1);
      end
    end
  end

`ifdef QUAD_INDEX_EN
  logic [IDX_W-1:0] r_index, w_index_nxt;
  logic             r_z;

  always_comb begin
    w_index_nxt = r_index;
    if (r_dir == DIR_FWD) w_index_nxt = (r_index == IDX_W'(CPR - 1)) ? '0 : (r_index + 1'b1);
    else                  w_index_nxt = (r_index == '0) ? IDX_W'(CPR - 1) : (r_index - 1'b1);
  end

  // Index pulse holds for the edge period, dropped when the command ends
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_index <= '0;
      r_z     <= 1'b0;
    end else begin
      if (w_adv) r_index <= w_index_nxt;
      if (w_state_nxt == ST_IDLE) r_z <= 1'b0;
      else if (w_adv)             r_z <= (w_index_nxt == '0) && (gray_of(w_phase_nxt) == 2'b00);
    end
  end

  assign quad_z = r_z;
`else
  logic [IDX_W-1:0] w_cpr_unused;
  assign w_cpr_unused = IDX_W'(CPR - 1);
  assign quad_z       = 1'b0;
`endif

  assign quad_a    = r_ab[1];
  assign quad_b    = r_ab[0];
  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_FINISH);
  assign position  = r_pos;

endmodule

// File: tb/tb_quad_generator.sv
// Randomized bench for quad_generator against an arithmetic timeline model.
module tb_quad_generator;

  localparam int CPR_TB = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_steps;
  logic [15:0] cmd_period;
  logic        abort;
  logic        quad_a, quad_b, quad_z, busy, done;
  logic [7:0]  position;

  int n_chk  = 0;
  int n_pass = 0;

  int m_phase = 0;
  int m_pos   = 0;
  int m_index = 0;
  int gtab[4] = '{0, 2, 3, 1};

  quad_generator #(.CPR(CPR_TB)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_steps (cmd_steps),
    .cmd_period(cmd_period),
    .abort     (abort),
    .quad_a    (quad_a),
    .quad_b    (quad_b),
    .quad_z    (quad_z),
    .busy      (busy),
    .done      (done),
    .position  (position)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s obs=%0d exp=%0d at %0t", tag, obs, exp, $time);
  endtask

  function automatic int wrap(input int v, input int m);
    return ((v % m) + m) % m;
  endfunction

  // Edges visible t cycles after the handshake; abort sampled at cycle a still lets edge kP=a+1 out
  function automatic int edges_at(input int t, input int n, input int p, input int a);
    int lim, e;
    lim = (a > 0 && t > a + 1) ? a + 1 : t;
    e   = lim / p;
    return (e > n) ? n : e;
  endfunction

  task automatic check_reset_outputs();
    check_eq("rst_ab",    {30'd0, quad_a, quad_b}, 0);
    check_eq("rst_z",     int'(quad_z), 0);
    check_eq("rst_busy",  int'(busy), 0);
    check_eq("rst_done",  int'(done), 0);
    check_eq("rst_pos",   int'(position), 0);
    check_eq("rst_ready", int'(cmd_ready), 1);
  endtask

  task automatic do_reset();
    cmd_valid  = 1'b0;
    abort      = 1'b0;
    cmd_steps  = '0;
    cmd_period = '0;
    rst        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    m_phase = 0;
    m_pos   = 0;
    m_index = 0;
  endtask

  task automatic run_cmd(input int steps, input int per, input int a, input int rst_at);
    int n, d, p, last, e, ef, ph, zexp;
    n    = (steps < 0) ? -steps : steps;
    d    = (steps < 0) ? -1 : 1;
    p    = (per < 2) ? 2 : per;
    last = (a > 0) ? a : n * p + 1;
    check_eq("ready_pre", int'(cmd_ready), 1);
    cmd_valid  = 1'b1;
    cmd_steps  = 16'(steps);
    cmd_period = 16'(per);
    abort      = 1'($urandom % 2);
    @(posedge clk);
    #1;
    for (int t = 1; ; t++) begin
      e  = edges_at(t, n, p, a);
      ph = wrap(m_phase + d * e, 4);
      check_eq("ab",    {30'd0, quad_a, quad_b}, gtab[ph]);
      check_eq("pos",   int'(position), wrap(m_pos + d * e, 256));
      check_eq("busy",  int'(busy), (t <= last) ? 1 : 0);
      check_eq("done",  int'(done), (a == 0 && t == n * p + 1) ? 1 : 0);
      check_eq("ready", int'(cmd_ready), (t > last) ? 1 : 0);
`ifdef QUAD_INDEX_EN
      zexp = (t <= last && e > 0 && wrap(m_index + d * e, CPR_TB) == 0 && ph == 0) ? 1 : 0;
`else
      zexp = 0;
`endif
      check_eq("z", int'(quad_z), zexp);
      if (t == rst_at) begin
        #2;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        rst       = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        m_phase = 0;
        m_pos   = 0;
        m_index = 0;
        return;
      end
      if (t == last + 1) break;
      abort     = (t == a);
      cmd_valid = 1'($urandom % 2);
      cmd_steps = 16'($urandom);
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    abort     = 1'b0;
    ef        = (a > 0) ? edges_at(a + 1, n, p, a) : n;
    m_phase   = wrap(m_phase + d * ef, 4);
    m_pos     = wrap(m_pos + d * ef, 256);
    m_index   = wrap(m_index + d * ef, CPR_TB);
  endtask

  initial begin
    int s, pr, ab, nn;
    do_reset();
    run_cmd(8, 4, 0, 0);
    check_eq("pos_plus8", int'(position), 8);
    do_reset();
    run_cmd(-3, 5, 0, 0);
    check_eq("pos_minus3", int'(position), 253);
    run_cmd(0, 7, 0, 0);
    run_cmd(2, 0, 0, 0);
    run_cmd(100, 3, 10, 0);
    check_eq("abort_ab_frozen", {30'd0, quad_a, quad_b}, gtab[m_phase]);
    for (int i = 0; i < 40; i++) begin
      s  = $urandom_range(40, 0) - 20;
      pr = $urandom_range(5, 0);
      nn = (s < 0) ? -s : s;
      ab = 0;
      if (nn > 0 && ($urandom % 4) == 0) ab = $urandom_range(nn * ((pr < 2) ? 2 : pr), 1);
      run_cmd(s, pr, ab, 0);
    end
    run_cmd(60, 3, 0, $urandom_range(150, 5));
    run_cmd(300, 1, 0, 0);
    check_eq("pos_wrap300", int'(position), 44);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/quad_generator.md
# quad_generator

Quadrature encoder emulator: the transmit end of the two-channel A/B encoder interface that the decoder and seven-segment display path consume. It accepts a signed step command with an edge period, then drives a glitch-free Gray-coded A/B pair, one transition per period, in the commanded direction. It also keeps an 8-bit position count for display. Bench and board use: drive the encoder inputs loop-back without a physical motor.

## Interface
- STEP_W, 16, width of signed step command
- PER_W, 16, width of edge period (clocks per A/B transition)
- MIN_PERIOD, 2, smallest legal period; smaller commands are clamped
- CPR, 1024, edges per revolution for index generation
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  generator idle, command accepted when cmd_valid & cmd_ready
- cmd_steps  in  STEP_W  signed edge count; positive = forward (A leads B)
- cmd_period  in  PER_W  clocks between successive edges
- abort  in  1  stop current command after the in-flight cycle
- quad_a  out  1  channel A
- quad_b  out  1  channel B
- quad_z  out  1  index pulse (macro-dependent)
- busy  out  1  command in progress
- done  out  1  one-cycle pulse on normal completion
- position  out  8  signed-step running count, wraps modulo 256

## Operation
- States: IDLE, RUN, FINISH. cmd_ready = (state == IDLE).
- IDLE: on handshake, latch |cmd_steps| into a STEP_W+1 remaining counter (so -2^(STEP_W-1) is exact), latch direction, latch max(cmd_period, MIN_PERIOD), load the period timer, go to RUN. If cmd_steps == 0, go directly to FINISH.
- RUN: the timer counts down; on expiry, advance the phase, decrement remaining, increment/decrement position, and reload the timer. When remaining reaches 0 after an edge, go to FINISH.
- FINISH: assert done for one cycle and return to IDLE.
- Phase sequence, forward, as {A,B}: 00 → 10 → 11 → 01 → 00. Reverse traverses it backwards. Exactly one of A/B changes per edge. Outputs are driven from registers only.
- Phase persists across commands; a new command continues from the current phase.
- abort in RUN or FINISH: go to IDLE next cycle. A/B hold their current phase, no done pulse, and position keeps edges already emitted. abort in IDLE is ignored.
- cmd_valid while busy: ignored, not queued.
- position: 8-bit two's complement wrap, 255 + 1 → 0 and 0 − 1 → 255.
- Reset values: quad_a=0, quad_b=0, quad_z=0, busy=0, done=0, position=0, cmd_ready=1, state IDLE. Reset mid-command discards the command immediately.

## Timing
- Handshake at clock edge T0. Edge k (k = 1..N) appears on A/B at T0 + k·P, where P = the clamped period.
- done is high during cycle T0 + N·P + 1. cmd_ready rises in the cycle after done; the next handshake is possible there.
- For N = 0: done is high at T0 + 1, with no A/B activity.
- busy is high from T0 + 1 through the done cycle inclusive.
- position updates in the same cycle as the corresponding A/B change.
- abort sampled at edge Ta: busy=0 and cmd_ready=1 from Ta + 1. If a timer expiry coincides with Ta, that edge is still emitted.

## Configuration
- QUAD_INDEX_EN defined:
  - An index counter runs modulo CPR, following the step direction and reset to 0.
  - quad_z is registered high while the index counter equals 0 and {A,B} == 00. It therefore lasts one edge period per revolution.
- QUAD_INDEX_EN undefined: the index counter is not built, and quad_z is tied to 0. The port always exists so top levels are unchanged.

## Structure
- Package quad_pkg holds:
  - the state enum (IDLE/RUN/FINISH)
  - the 4-entry Gray phase table
  - forward/reverse direction constants
  - the default MIN_PERIOD
- One sub-module, quad_step_timer: a loadable down-counter of width PER_W with a one-cycle expiry pulse and a synchronous reload. The FSM, phase register, position and index logic stay in quad_generator.

## Test plan
- Reset, then steps=+8, period=4: A/B follow 10,11,01,00,10,11,01,00 at T0+4, +8, … +32. done is high at T0+33; position=8.
- steps=−3, period=5 from phase 00: the sequence is 01,11,10; position 0 → 253; done at T0+16.
- steps=0: done at T0+1 with no A/B change. Then period=0 with steps=2: edges appear at T0+2 and T0+4 (clamp to MIN_PERIOD).
- steps=+100, period=3, abort asserted at T0+10 (coincident expiry at T0+9 already passed):
  - 3 edges are emitted and A/B freeze;
  - no done pulse;
  - cmd_ready=1 at T0+11.
- With QUAD_INDEX_EN, CPR=8, steps=+16, period=2: quad_z is high for 2 cycles starting at edges 8 and 16. Without the macro, quad_z stays 0 throughout.
- Reset asserted mid-run at an arbitrary cycle: all outputs go to their reset values immediately. Also check that the position wraps correctly over +300 steps (reads 44).
